// File: rtl/apb_cmd_sequencer_pkg.sv
// Shared definitions for the APB command sequencer: default widths, FSM state type and the
// register map of the attached slave.
package apb_cmd_sequencer_pkg;

  localparam int unsigned DefAw      = 32;
  localparam int unsigned DefDw      = 32;
  localparam int unsigned DefDepth   = 4;
  localparam int unsigned DefTimeout = 16;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } seq_state_e;

  // Slave register map: A and B are read/write, C is write-only, D is read-only.
  localparam logic [31:0] REGA_ADDR = 32'd5;
  localparam logic [31:0] REGB_ADDR = 32'd10;
  localparam logic [31:0] REGC_ADDR = 32'd15;
  localparam logic [31:0] REGD_ADDR = 32'd20;

endpackage

// File: rtl/apb_cmd_sequencer_if.sv
// Host command/response and APB-master request/completion signals of the sequencer.
// The slave modport is the sequencer's view; master is the view of whoever drives it.
interface apb_cmd_sequencer_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_wr;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  logic          m_start_valid;
  logic          m_st_wr_rd;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;
  logic [AW-1:0] m_rd_addr;
  logic [DW-1:0] m_rd_data;
  logic          m_done;
  logic          m_slverr;

  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, m_rd_data, m_done, m_slverr,
    output cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err,
    output m_start_valid, m_st_wr_rd, m_wr_addr, m_wr_data, m_rd_addr
  );

  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, m_rd_data, m_done, m_slverr,
    input  cmd_ready, rsp_valid, rsp_wr, rsp_rdata, rsp_err,
    input  m_start_valid, m_st_wr_rd, m_wr_addr, m_wr_data, m_rd_addr
  );

endinterface

// File: rtl/apb_cmd_sequencer_fifo.sv
// Synchronous command FIFO with full/empty flags. Pushes while full and pops while empty are
// dropped, so callers may present requests unconditionally.
module apb_cmd_sequencer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [PW:0]   FullCnt = DEPTH[PW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FullCnt);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/apb_cmd_sequencer.sv
// Buffers host commands and replays them one at a time onto the APB master request port,
// returning each completion (or a watchdog timeout) as a handshaked response.
module apb_cmd_sequencer
  import apb_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned AW      = DefAw,
  parameter int unsigned DW      = DefDw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input logic                clk,
  input logic                rst,
  apb_cmd_sequencer_if.slave bus
);

  localparam int unsigned     FW       = 1 + AW + DW;
  localparam int unsigned     CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   WdogLast = CW'(TIMEOUT - 1);

  seq_state_e    state_q;
  logic          start_q, wr_q;
  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [CW-1:0] wdog_q;
  logic          rsp_valid_q, rsp_wr_q, rsp_err_q;
  logic [DW-1:0] rsp_rdata_q;

  logic          fifo_full, fifo_empty, pop;
  logic [FW-1:0] fifo_head;
  logic          head_wr;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  apb_cmd_sequencer_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.cmd_valid),
    .push_data ({bus.cmd_wr, bus.cmd_addr, bus.cmd_wdata}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_wr   = fifo_head[FW-1];
  assign head_addr = fifo_head[DW +: AW];
  assign head_data = fifo_head[DW-1:0];

  // Pop from idle, or straight out of a response being accepted for back-to-back issue.
  assign pop = !fifo_empty &&
               ((state_q == StIdle) || ((state_q == StResp) && bus.rsp_ready));

  // Sequencer FSM with registered request and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      wr_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      wdog_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StIdle: ;
        StIssue: begin
          // Counting from the pulse cycle makes the timeout land TIMEOUT cycles after it.
          wdog_q  <= wdog_q + 1'b1;
          state_q <= StWait;
        end
        StWait: begin
          if (bus.m_done) begin
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= wr_q;
            rsp_err_q   <= bus.m_slverr;
            rsp_rdata_q <= (!wr_q && !bus.m_slverr) ? bus.m_rd_data : '0;
            state_q     <= StResp;
          end else if (wdog_q == WdogLast) begin
            rsp_valid_q <= 1'b1;
            rsp_wr_q    <= wr_q;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= StResp;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Issue overrides the idle/response transitions above.
      if (pop) begin
        state_q   <= StIssue;
        start_q   <= 1'b1;
        wr_q      <= head_wr;
        wr_addr_q <= head_wr ? head_addr : '0;
        wr_data_q <= head_wr ? head_data : '0;
        rd_addr_q <= head_wr ? '0 : head_addr;
        wdog_q    <= '0;
      end
    end
  end

  assign bus.cmd_ready     = !fifo_full;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_wr        = rsp_wr_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.m_start_valid = start_q;
  assign bus.m_st_wr_rd    = wr_q;
  assign bus.m_wr_addr     = wr_addr_q;
  assign bus.m_wr_data     = wr_data_q;
  assign bus.m_rd_addr     = rd_addr_q;

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Self-checking bench: the bench plays host, stub APB master and slave register file.
// Expected traffic comes from a transaction-level model (queues plus a register map).
module tb_apb_cmd_sequencer;
  import apb_cmd_sequencer_pkg::*;

  localparam int unsigned Depth   = 4;
  localparam int unsigned Aw      = 32;
  localparam int unsigned Dw      = 32;
  localparam int unsigned Timeout = 16;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hang;
  } cmd_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  apb_cmd_sequencer_if #(.AW(Aw), .DW(Dw)) bus ();

  apb_cmd_sequencer #(
    .DEPTH   (Depth),
    .AW      (Aw),
    .DW      (Dw),
    .TIMEOUT (Timeout)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  cmd_t stim_q[$];   // commands not yet accepted by the DUT
  cmd_t fifo_q[$];   // accepted, not yet issued
  cmd_t cur_cmd;
  rsp_t cur_exp;
  bit   busy = 0, in_wait = 0, exp_start = 0;
  int   cyc = 0, start_cyc = 0, done_at = 0, rsp_due = 0;
  int   rr_mode = 1;   // 0 random, 1 always ready, 2 never ready
  int   push_pct = 100;
  logic [31:0] reg_a = '0, reg_b = '0, reg_c = '0;
  logic [31:0] reg_d = 32'h0000_d00d;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(logic wr, logic [31:0] addr, logic [31:0] data, bit hang);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.data = data; c.hang = hang;
    return c;
  endfunction

  // Slave register file, applied in command order; a hung transfer never reaches it.
  function automatic rsp_t slave_model(cmd_t c);
    rsp_t r;
    r.wr = c.wr; r.rdata = '0; r.err = 1'b0;
    if (c.hang) begin
      r.err = 1'b1;
    end else if (c.wr) begin
      if (c.addr == REGA_ADDR)      reg_a = c.data;
      else if (c.addr == REGB_ADDR) reg_b = c.data;
      else if (c.addr == REGC_ADDR) reg_c = c.data;
      else                          r.err = 1'b1;
    end else begin
      if (c.addr == REGA_ADDR)      r.rdata = reg_a;
      else if (c.addr == REGB_ADDR) r.rdata = reg_b;
      else if (c.addr == REGD_ADDR) r.rdata = reg_d;
      else                          r.err = 1'b1;
    end
    return r;
  endfunction

  // One clock cycle: observe at the falling edge, then drive inputs for the next rising edge.
  task automatic step();
    bit exp_rv, rr;
    @(negedge clk);
    cyc++;

    check_eq("start_pulse", bus.m_start_valid, exp_start);
    if (bus.m_start_valid && exp_start) begin
      cur_cmd = fifo_q.pop_front();
      check_eq("st_wr_rd", bus.m_st_wr_rd, cur_cmd.wr);
      check_eq("wr_addr", bus.m_wr_addr, cur_cmd.wr ? cur_cmd.addr : 32'd0);
      check_eq("wr_data", bus.m_wr_data, cur_cmd.wr ? cur_cmd.data : 32'd0);
      check_eq("rd_addr", bus.m_rd_addr, cur_cmd.wr ? 32'd0 : cur_cmd.addr);
      cur_exp   = slave_model(cur_cmd);
      busy      = 1;
      in_wait   = 1;
      start_cyc = cyc;
      if (cur_cmd.hang) begin
        rsp_due = cyc + Timeout;
      end else begin
        done_at = cyc + (($urandom_range(0, 4) == 0) ? Timeout - 1 : $urandom_range(1, 4));
        rsp_due = done_at + 1;
      end
    end

    check_eq("cmd_ready", bus.cmd_ready, fifo_q.size() < Depth);

    exp_rv = busy && (cyc >= rsp_due);
    if (busy && in_wait && cur_cmd.hang && exp_rv) in_wait = 0;
    check_eq("rsp_valid", bus.rsp_valid, exp_rv);
    if (exp_rv) begin
      check_eq("rsp_wr", bus.rsp_wr, cur_exp.wr);
      check_eq("rsp_rdata", bus.rsp_rdata, cur_exp.rdata);
      check_eq("rsp_err", bus.rsp_err, cur_exp.err);
    end
    rr = (rr_mode == 1) || ((rr_mode == 0) && ($urandom_range(0, 3) != 0));
    bus.rsp_ready = rr;
    if (exp_rv && rr) busy = 0;

    // Issue follows on the next edge whenever the sequencer is free and commands wait.
    exp_start = !busy && (fifo_q.size() > 0);

    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = $urandom_range(0, 1);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    if (stim_q.size() > 0 && $urandom_range(0, 99) < push_pct) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = stim_q[0].wr;
      bus.cmd_addr  = stim_q[0].addr;
      bus.cmd_wdata = stim_q[0].data;
      if (bus.cmd_ready) fifo_q.push_back(stim_q.pop_front());
    end

    bus.m_done    = 1'b0;
    bus.m_slverr  = $urandom_range(0, 1);
    bus.m_rd_data = $urandom;
    if (busy && in_wait && !cur_cmd.hang && cyc == done_at) begin
      bus.m_done    = 1'b1;
      bus.m_slverr  = cur_exp.err;
      bus.m_rd_data = (cur_exp.err || cur_cmd.wr) ? $urandom : cur_exp.rdata;
      in_wait       = 0;
    end else if (!in_wait && $urandom_range(0, 7) == 0) begin
      bus.m_done = 1'b1;  // stray completion the sequencer must ignore
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((stim_q.size() > 0 || fifo_q.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    check_eq("drain", (stim_q.size() > 0 || fifo_q.size() > 0 || busy), 0);
  endtask

  initial begin
    int n;
    bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 0; bus.m_rd_data = '0; bus.m_done = 0; bus.m_slverr = 0;

    repeat (2) @(negedge clk);
    check_eq("rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("rst_start", bus.m_start_valid, 0);
    check_eq("rst_st_wr_rd", bus.m_st_wr_rd, 0);
    check_eq("rst_wr_addr", bus.m_wr_addr, 0);
    check_eq("rst_rd_addr", bus.m_rd_addr, 0);
    check_eq("rst_rsp_err", bus.rsp_err, 0);
    rst = 1'b1;

    // Directed register-map traffic, including a hung transfer and back-to-back writes.
    rr_mode = 1; push_pct = 100;
    stim_q.push_back(mk(1, REGA_ADDR, 99, 0));
    stim_q.push_back(mk(0, REGA_ADDR, 0, 0));
    stim_q.push_back(mk(1, REGB_ADDR, 52, 0));
    stim_q.push_back(mk(0, REGB_ADDR, 0, 0));
    for (int i = 0; i < 4; i++) stim_q.push_back(mk(1, REGC_ADDR, 54 - i, 0));
    stim_q.push_back(mk(0, REGC_ADDR, 0, 0));
    stim_q.push_back(mk(1, REGD_ADDR, 45, 0));
    stim_q.push_back(mk(0, REGD_ADDR, 0, 0));
    stim_q.push_back(mk(1, REGA_ADDR, 7, 1));
    stim_q.push_back(mk(0, REGA_ADDR, 0, 0));
    drain(1000);

    // Response back-pressure with enough commands queued to fill the FIFO.
    for (int i = 0; i < 6; i++) stim_q.push_back(mk(0, REGB_ADDR, 0, 0));
    rr_mode = 2;
    repeat (14) step();
    rr_mode = 1;
    drain(1000);

    // Randomized traffic.
    rr_mode = 0; push_pct = 60;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 4))
        0: a = REGA_ADDR;
        1: a = REGB_ADDR;
        2: a = REGC_ADDR;
        3: a = REGD_ADDR;
        default: a = 32'd7;
      endcase
      stim_q.push_back(mk($urandom_range(0, 1), a, $urandom, $urandom_range(0, 11) == 0));
    end
    drain(5000);

    // Reset while a hung transfer sits in WAIT with another command queued.
    rr_mode = 1; push_pct = 100;
    stim_q.push_back(mk(0, REGA_ADDR, 0, 1));
    stim_q.push_back(mk(0, REGB_ADDR, 0, 0));
    n = 0;
    while (!(busy && in_wait && cyc >= start_cyc + 3) && n < 100) begin
      step();
      n++;
    end
    check_eq("reached_wait", busy && in_wait, 1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check_eq("mid_rst_cmd_ready", bus.cmd_ready, 1);
    check_eq("mid_rst_start", bus.m_start_valid, 0);
    stim_q.delete();
    fifo_q.delete();
    busy = 0; in_wait = 0; exp_start = 0;
    bus.cmd_valid = 0; bus.m_done = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
